// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised FIFO family.
// Pointer and occupancy widths are derived here so top and RAM always agree.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width for a DEPTH-entry array; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; pointers and
    // count already make stale contents unreachable after reset or clear.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // NOTE: non-blocking assignments give read-before-write on a shared address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      rdata <= '0;
        else if (clear)  rdata <= '0;
        else if (re)     rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy, thresholds, sticky error
// flags and optional first-word-fall-through output staging.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FIFO_MODE_STD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         write,
    input  logic                         read,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    ram_cnt;
    logic [WIDTH-1:0] ram_rdata, byp_data;
    logic             byp_sel;
    logic             rd_ok, wr_ok, stage_free;
    logic             ram_we, ram_re, byp_load;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        empty        = (count == '0);
        full         = (count == CW'(DEPTH));
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
        rd_ok        = read && !empty;
        wr_ok        = write && (!full || rd_ok);
        ram_cnt      = empty ? '0 : count - CW'(1);
        stage_free   = empty || rd_ok;
        ram_we       = wr_ok;
        ram_re       = rd_ok;
        byp_load     = 1'b0;
        // In FWFT the head word lives in the output stage, so the RAM holds
        // count-1 words; a write into an empty stage skips the RAM entirely.
        if (FWFT == FIFO_MODE_FWFT) begin
            ram_re   = stage_free && (ram_cnt != '0);
            byp_load = stage_free && (ram_cnt == '0) && wr_ok;
            ram_we   = wr_ok && !byp_load;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            byp_sel   <= 1'b0;
            byp_data  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            byp_sel   <= 1'b0;
            byp_data  <= '0;
        end else begin
            if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
            if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_ok && !rd_ok)      count <= count + CW'(1);
            else if (rd_ok && !wr_ok) count <= count - CW'(1);
            if (write && !wr_ok) overflow  <= 1'b1;
            if (read && empty)   underflow <= 1'b1;
            if (ram_re) begin
                byp_sel <= 1'b0;
            end else if (byp_load) begin
                byp_sel  <= 1'b1;
                byp_data <= data_in;
            end
        end
    end

    assign data_out = byp_sel ? byp_data : ram_rdata;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_param_fifo.sv
// Drives a registered-read and an FWFT instance with the same stimulus and
// checks both against a queue model every cycle, plus literal spot checks.
module tb_param_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clock, reset, clear, write, read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] s_dout, f_dout;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]       s_count, f_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_unf;

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clock(clock), .reset(reset), .clear(clear), .write(write), .read(read),
        .data_in(data_in), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clock(clock), .reset(reset), .clear(clear), .write(write), .read(read),
        .data_in(data_in), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: occupancy is the queue size, the registered output is the
    // last popped word, the FWFT output is the queue head.
    always @(posedge clock or negedge reset) begin
        if (!reset || clear) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 0;
            m_unf  = 0;
        end else begin
            bit rd, wr;
            rd = read && (q.size() > 0);
            wr = write && ((q.size() < DEPTH) || rd);
            if (write && !wr)              m_ovf = 1;
            if (read && (q.size() == 0))   m_unf = 1;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(data_in);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int n;
            n = q.size();
            check("s_count", 32'(s_count), n);
            check("f_count", 32'(f_count), n);
            check("s_empty", 32'(s_empty), 32'(n == 0));
            check("f_empty", 32'(f_empty), 32'(n == 0));
            check("s_full",  32'(s_full),  32'(n == DEPTH));
            check("f_full",  32'(f_full),  32'(n == DEPTH));
            check("s_af",    32'(s_af),    32'(n >= AF));
            check("f_af",    32'(f_af),    32'(n >= AF));
            check("s_ae",    32'(s_ae),    32'(n <= AE));
            check("f_ae",    32'(f_ae),    32'(n <= AE));
            check("s_ovf",   32'(s_ovf),   32'(m_ovf));
            check("f_ovf",   32'(f_ovf),   32'(m_ovf));
            check("s_unf",   32'(s_unf),   32'(m_unf));
            check("f_unf",   32'(f_unf),   32'(m_unf));
            check("s_dout",  32'(s_dout),  32'(m_dout));
            if (n > 0) check("f_dout", 32'(f_dout), 32'(q[0]));
        end
    end

    task automatic apply(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
        write   = w;
        read    = r;
        clear   = c;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    logic [WIDTH-1:0] t4_exp [6];
    logic [WIDTH-1:0] t4_w   [12];
    logic             t4_r   [12];

    initial begin
        int k;
        reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
        #1 reset = 1'b0;
        chk_en = 1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Reset state
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_ae",    32'(s_ae), 1);
        check("rst_dout",  32'(s_dout), 0);

        // 1: fill then drain in order
        apply(1, 0, 0, 100); check("t1_cnt1", 32'(s_count), 1); check("t1_af1", 32'(s_af), 0);
        apply(1, 0, 0, 150); check("t1_cnt2", 32'(s_count), 2); check("t1_ae2", 32'(s_ae), 0);
        apply(1, 0, 0, 200); check("t1_af3", 32'(s_af), 1); check("t1_full3", 32'(s_full), 0);
        apply(1, 0, 0, 40);  check("t1_full4", 32'(s_full), 1); check("t1_fhead", 32'(f_dout), 100);
        apply(0, 1, 0, 0);   check("t1_rd1", 32'(s_dout), 100);
        apply(0, 1, 0, 0);   check("t1_rd2", 32'(s_dout), 150);
        apply(0, 1, 0, 0);   check("t1_rd3", 32'(s_dout), 200);
        apply(0, 1, 0, 0);   check("t1_rd4", 32'(s_dout), 40);
        check("t1_empty", 32'(s_empty), 1);

        // 2: overflow, then simultaneous read/write while full
        apply(1, 0, 0, 100); apply(1, 0, 0, 150); apply(1, 0, 0, 200); apply(1, 0, 0, 40);
        apply(1, 0, 0, 70);  check("t2_ovf", 32'(s_ovf), 1); check("t2_cnt", 32'(s_count), 4);
        apply(1, 1, 0, 65);  check("t2_rw_dout", 32'(s_dout), 100); check("t2_rw_cnt", 32'(s_count), 4);
        apply(0, 1, 0, 0); apply(0, 1, 0, 0); apply(0, 1, 0, 0); apply(0, 1, 0, 0);
        check("t2_last", 32'(s_dout), 65);

        // 3: underflow on empty, clear drops flags
        apply(0, 1, 0, 0);   check("t3_unf", 32'(s_unf), 1); check("t3_hold", 32'(s_dout), 65);
        check("t3_cnt", 32'(s_count), 0);
        apply(0, 0, 1, 0);   check("t3_ovf_clr", 32'(s_ovf), 0); check("t3_unf_clr", 32'(s_unf), 0);

        // 4: interleaved traffic across pointer wrap
        t4_exp = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd66};
        t4_w   = '{16'd11, 16'd22, 16'd33, 16'd0, 16'd44, 16'd55, 16'd0, 16'd66, 16'd0, 16'd0, 16'd0, 16'd0};
        t4_r   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        k = 0;
        for (int i = 0; i < 12; i++) begin
            apply(!t4_r[i], t4_r[i], 0, t4_w[i]);
            check("t4_cnt_le4", 32'(s_count <= 3'd4), 1);
            if (t4_r[i]) begin
                check("t4_order", 32'(s_dout), 32'(t4_exp[k]));
                k++;
            end
        end
        check("t4_nreads", k, 6);

        // 5: FWFT fall-through on write into empty
        apply(1, 0, 0, 230); check("t5_fempty", 32'(f_empty), 0); check("t5_fdout", 32'(f_dout), 230);
        apply(0, 0, 0, 0);   check("t5_fhold", 32'(f_dout), 230);
        apply(0, 1, 0, 0);   check("t5_fempty2", 32'(f_empty), 1); check("t5_sdout", 32'(s_dout), 230);

        // 6: clear overrides a write; async reset mid-burst
        apply(1, 0, 0, 1); apply(1, 0, 0, 2); apply(1, 0, 0, 3);
        apply(1, 0, 1, 99);  check("t6_clr_cnt", 32'(s_count), 0); check("t6_clr_empty", 32'(s_empty), 1);
        apply(0, 0, 0, 0);   check("t6_clr_noacc", 32'(f_count), 0);
        apply(1, 0, 0, 7); apply(1, 0, 0, 8); apply(1, 0, 0, 9); apply(1, 0, 0, 10);
        apply(1, 0, 0, 12);  check("t6_ovf", 32'(s_ovf), 1);
        apply(0, 1, 0, 0);   check("t6_dout7", 32'(s_dout), 7);
        write = 1'b1; data_in = 16'd14;
        #2 reset = 1'b0;
        #1;
        check("t6_rst_cnt",   32'(s_count), 0);
        check("t6_rst_empty", 32'(s_empty), 1);
        check("t6_rst_full",  32'(s_full), 0);
        check("t6_rst_ae",    32'(s_ae), 1);
        check("t6_rst_af",    32'(s_af), 0);
        check("t6_rst_dout",  32'(s_dout), 0);
        check("t6_rst_fdout", 32'(f_dout), 0);
        check("t6_rst_ovf",   32'(s_ovf), 0);
        check("t6_rst_fcnt",  32'(f_count), 0);
        #20 reset = 1'b1;
        apply(0, 0, 0, 0);
        check("t6_post_cnt", 32'(s_count), 0);
        apply(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
